// File: rtl/pregfile_wb_arbiter.sv
// Writeback arbiter: NUM_SRC one-entry result buffers drained round-robin onto
// the two physical-register-file write ports.
module pregfile_wb_arbiter #(
  parameter int NUM_SRC = 4,
  parameter int DATA_W  = 64,
  parameter int PREG_W  = 6
) (
  input  logic                      clock,
  input  logic                      reset_n,
  input  logic                      flush,
  input  logic [NUM_SRC-1:0]        src_valid,
  output logic [NUM_SRC-1:0]        src_ready,
  input  logic [NUM_SRC*PREG_W-1:0] src_addr,
  input  logic [NUM_SRC*DATA_W-1:0] src_data,
  output logic                      wren0,
  output logic [PREG_W-1:0]         waddr0,
  output logic [DATA_W-1:0]         wdata0,
  output logic                      wren1,
  output logic [PREG_W-1:0]         waddr1,
  output logic [DATA_W-1:0]         wdata1,
  output logic [31:0]               conflict_cnt
);

  localparam int PTR_W = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1;
  localparam logic [PTR_W:0]   NUM_SRC_W = (PTR_W+1)'(NUM_SRC);
  localparam logic [PTR_W-1:0] LAST_IDX  = PTR_W'(NUM_SRC - 1);

  logic [NUM_SRC-1:0] buf_vld_reg;
  logic [NUM_SRC-1:0] buf_vld_next;
  logic [PREG_W-1:0]  buf_addr_reg [NUM_SRC];
  logic [DATA_W-1:0]  buf_data_reg [NUM_SRC];
  logic [PTR_W-1:0]   rr_ptr_reg;
  logic [PTR_W-1:0]   rr_ptr_next;
  logic [31:0]        conflict_cnt_reg;

  logic [NUM_SRC-1:0] grant;
  logic [NUM_SRC-1:0] load;
  logic               g0_found, g1_found;
  logic [PTR_W-1:0]   g0_idx, g1_idx, last_idx;
  logic [PTR_W:0]     scan_sum;
  logic [PTR_W-1:0]   scan_idx;

  // Scan from rr_ptr modulo NUM_SRC; first valid buffer -> port 0, second -> port 1.
  always_comb begin
    g0_found = 1'b0;
    g1_found = 1'b0;
    g0_idx   = '0;
    g1_idx   = '0;
    scan_sum = '0;
    scan_idx = '0;
    for (int k = 0; k < NUM_SRC; k++) begin
      scan_sum = {1'b0, rr_ptr_reg} + (PTR_W+1)'(k);
      if (scan_sum >= NUM_SRC_W) scan_sum = scan_sum - NUM_SRC_W;
      scan_idx = scan_sum[PTR_W-1:0];
      if (buf_vld_reg[scan_idx] && !flush) begin
        if (!g0_found) begin
          g0_found = 1'b1;
          g0_idx   = scan_idx;
        end else if (!g1_found) begin
          g1_found = 1'b1;
          g1_idx   = scan_idx;
        end
      end
    end
  end

  always_comb begin
    grant = '0;
    if (g0_found) grant[g0_idx] = 1'b1;
    if (g1_found) grant[g1_idx] = 1'b1;
  end

  assign wren0  = g0_found;
  assign waddr0 = g0_found ? buf_addr_reg[g0_idx] : '0;
  assign wdata0 = g0_found ? buf_data_reg[g0_idx] : '0;
  assign wren1  = g1_found;
  assign waddr1 = g1_found ? buf_addr_reg[g1_idx] : '0;
  assign wdata1 = g1_found ? buf_data_reg[g1_idx] : '0;

  assign last_idx    = g1_found ? g1_idx : g0_idx;
  assign rr_ptr_next = (last_idx == LAST_IDX) ? '0 : last_idx + 1'b1;

  generate
    for (genvar gi = 0; gi < NUM_SRC; gi++) begin : g_src
      assign src_ready[gi] = (!buf_vld_reg[gi] || grant[gi]) && !flush;
      // Writes to preg 0 complete the handshake but are never buffered.
      assign load[gi] = src_valid[gi] && src_ready[gi] &&
                        (src_addr[gi*PREG_W +: PREG_W] != '0);
      assign buf_vld_next[gi] = flush      ? 1'b0 :
                                load[gi]   ? 1'b1 :
                                grant[gi]  ? 1'b0 : buf_vld_reg[gi];
    end
  endgenerate

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      buf_vld_reg      <= '0;
      rr_ptr_reg       <= '0;
      conflict_cnt_reg <= '0;
    end else begin
      buf_vld_reg <= buf_vld_next;
      if (|grant) rr_ptr_reg <= rr_ptr_next;
      if (!flush && ($countones(buf_vld_reg) > 2) && (conflict_cnt_reg != 32'hFFFF_FFFF))
        conflict_cnt_reg <= conflict_cnt_reg + 32'd1;
    end
  end

  // Payload storage needs no reset: it is only observed behind buf_vld_reg.
  always_ff @(posedge clock) begin
    for (int i = 0; i < NUM_SRC; i++) begin
      if (load[i]) begin
        buf_addr_reg[i] <= src_addr[i*PREG_W +: PREG_W];
        buf_data_reg[i] <= src_data[i*DATA_W +: DATA_W];
      end
    end
  end

  assign conflict_cnt = conflict_cnt_reg;

endmodule
